mem_initiator: RTL and testbench
================================

# mem_initiator

Memory access initiator on the CPU side of the 8-bit core's single-port synchronous RAM (4096 x 8, one-cycle registered read, write-or-read per cycle). It accepts two level-held requests, instruction fetch and data load/store, and arbitrates between them with fixed priority. It drives the RAM address, write-enable and write-data from registers, waits out the RAM read latency, and returns read data with a one-cycle acknowledge pulse.

## Interface
- `ADDR_WIDTH`, default 12: RAM address width.
- `DATA_WIDTH`, default 8: RAM data width.

Ports (name, direction, width, meaning):
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `if_req` in 1: instruction fetch read request; held until `if_ack`.
- `if_addr` in ADDR_WIDTH: fetch address.
- `if_ack` out 1: one-cycle pulse; `if_rdata` is valid.
- `if_rdata` out DATA_WIDTH: fetched byte; held until the next fetch completes.
- `d_req` in 1: data request; held until `d_ack`.
- `d_we` in 1: 1 = store, 0 = load.
- `d_addr` in ADDR_WIDTH: data address.
- `d_wdata` in DATA_WIDTH: store data.
- `d_ack` out 1: one-cycle pulse; store done, or load data valid.
- `d_rdata` out DATA_WIDTH: loaded byte; held until the next load completes.
- `mem_addr` out ADDR_WIDTH: to RAM address.
- `mem_we` out 1: to RAM write-enable.
- `mem_wdata` out DATA_WIDTH: to RAM write data.
- `mem_rdata` in DATA_WIDTH: from RAM registered read data.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, ISSUE, RD_WAIT, DONE.
- **IDLE:**
  - If `d_req`: latch `d_addr`, `d_we`, `d_wdata` into the mem registers, record owner = DATA, go to ISSUE.
  - Else if `if_req`: latch `if_addr`, set `mem_we` = 0, owner = FETCH, go to ISSUE.
  - Else stay in IDLE.
- **ISSUE:** RAM performs the access on this cycle's closing edge.
  - Write: go to DONE.
  - Read: go to RD_WAIT.
- **RD_WAIT:** `mem_rdata` is now valid. On the closing edge, capture it into `d_rdata` or `if_rdata` according to owner, then go to DONE.
- **DONE:** the owner's ack is high for exactly this cycle. Go to IDLE unconditionally.
- Request rules:
  - The requester deasserts or changes its request on the edge where it samples ack.
  - IDLE samples requests no earlier than the edge after DONE, so no request is accepted twice.
- Arbitration is fixed priority, data over fetch. A losing fetch stays pending and is served after the data transaction completes.
- `mem_we` is high only in ISSUE with owner DATA and a latched store. This means `mem_we` = 1 never lasts more than one cycle per store.
- `mem_addr` and `mem_wdata` hold their last value outside transactions.
- Request inputs are ignored outside IDLE.
- The non-owner's ack and rdata are never disturbed.

## Timing
- Request sampled at edge E0 enters ISSUE.
  - Store: `d_ack` is high between E1 and E2; 2-cycle latency.
  - Load or fetch: ack and new rdata are visible between E2 and E3; 3-cycle latency.
- Back-to-back throughput:
  - Store: one per 3 cycles.
  - Read: one per 4 cycles.
- Reset values:
  - State = IDLE.
  - `mem_addr`, `mem_wdata`, `if_rdata`, `d_rdata` = 0.
  - `mem_we`, `if_ack`, `d_ack`, `busy` = 0.
- Reset asserted mid-transaction:
  - `mem_we` drops immediately, because it is asynchronous.
  - The transaction is aborted and no ack is issued.
  - After reset release, still-held requests are re-arbitrated from IDLE.

## Structure
- Shared package `mem_pkg`:
  - FSM state enum (IDLE, ISSUE, RD_WAIT, DONE).
  - Owner enum (FETCH, DATA).
  - Default ADDR_WIDTH and DATA_WIDTH constants, reused by the RAM.
- Optional combinational sub-module `mem_prio_arb`: two requests in, grant plus owner out.
- All other logic lives in a single FSM plus datapath registers.

## Test plan
- **Reset:** assert `reset` mid-run, then release → all outputs 0, `busy` = 0.
- **Store then load:** `d_req` with `d_we` = 1, `d_addr` = 0x005, `d_wdata` = 0xA5 → `d_ack` 2 cycles later, `mem_we` high exactly 1 cycle. Then a load from 0x005 → `d_ack` 3 cycles later, `d_rdata` = 0xA5.
- **Fetch:** fetch from `if_addr` = 0x000 with the RAM preloaded to 0xF0 → `if_ack` 3 cycles later, `if_rdata` = 0xF0, `d_rdata` unchanged.
- **Simultaneous requests:** `if_req` (0x001) and a `d_req` load (0x002) raised on the same edge → `d_ack` first, `if_ack` 4 cycles later, each with the correct byte.
- **Reset mid-store:** assert `reset` while in ISSUE of a store to 0x010 = 0x55 → `mem_we` falls immediately, no `d_ack`, RAM[0x010] unchanged.
- **Back-to-back loads:** 4 loads from 0x100–0x103 → `d_ack` every 4 cycles with matching data, no missed or duplicated ack.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and default geometry for the core's single-port RAM and its initiator.
package mem_pkg;

    localparam int unsigned DEF_ADDR_WIDTH = 12;
    localparam int unsigned DEF_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RD_WAIT = 2'd2,
        DONE    = 2'd3
    } state_t;

    typedef enum logic {
        FETCH = 1'b0,
        DATA  = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_prio_arb.sv
// Fixed-priority arbiter: data requests always win over instruction fetch.
module mem_prio_arb
    import mem_pkg::*;
(
    input  logic   if_req,
    input  logic   d_req,
    output logic   grant_c,
    output owner_t owner_c
);

    always_comb begin
        grant_c = if_req | d_req;
        owner_c = d_req ? DATA : FETCH;
    end

endmodule

// File: rtl/mem_initiator.sv
// CPU-side RAM access initiator: arbitrates fetch/data requests, drives the RAM
// from registers, waits out the registered read and returns data with an ack pulse.
module mem_initiator
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_ack,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_ack,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy
);

    state_t state;
    owner_t owner;
    logic   grant_c;
    owner_t grant_owner_c;

    mem_prio_arb u_arb (
        .if_req  (if_req),
        .d_req   (d_req),
        .grant_c (grant_c),
        .owner_c (grant_owner_c)
    );

    // mem_we is only ever set on the IDLE->ISSUE edge, so it lasts exactly one cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            owner     <= FETCH;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            if_ack    <= 1'b0;
            d_ack     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            if_ack <= 1'b0;
            d_ack  <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_c) begin
                        state <= ISSUE;
                        busy  <= 1'b1;
                        owner <= grant_owner_c;
                        if (grant_owner_c == DATA) begin
                            mem_addr  <= d_addr;
                            mem_we    <= d_we;
                            mem_wdata <= d_wdata;
                        end else begin
                            mem_addr <= if_addr;
                        end
                    end
                end
                ISSUE: begin
                    if (mem_we) begin
                        state <= DONE;
                        d_ack <= 1'b1;
                    end else begin
                        state <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    state <= DONE;
                    if (owner == DATA) begin
                        d_rdata <= mem_rdata;
                        d_ack   <= 1'b1;
                    end else begin
                        if_rdata <= mem_rdata;
                        if_ack   <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_initiator.sv
// Bench for mem_initiator: behavioural RAM, vector table, ack scoreboard and reset corner cases.
module tb_mem_initiator;

    typedef struct {
        logic        is_data;
        logic        is_read;
        logic [7:0]  data;
        int          due;
    } exp_t;

    typedef struct {
        logic        is_fetch;
        logic        we;
        logic [11:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  exp_data;
        int          lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [11:0] if_addr;
    logic        if_ack;
    logic [7:0]  if_rdata;
    logic        d_req;
    logic        d_we;
    logic [11:0] d_addr;
    logic [7:0]  d_wdata;
    logic        d_ack;
    logic [7:0]  d_rdata;
    logic [11:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        busy;

    logic        preload;
    logic [7:0]  ram [0:4095];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    exp_t        sb [$];
    logic [7:0]  exp_d_rdata;
    logic [7:0]  exp_if_rdata;
    int          we_pulses;
    logic        prev_we;
    vec_t        vecs [8];

    mem_initiator dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ack    (if_ack),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // 4096 x 8 RAM with one-cycle registered read
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 4096; i++) ram[i] <= 8'h00;
            ram[12'h000] <= 8'hF0;
            ram[12'h001] <= 8'h11;
            ram[12'h002] <= 8'h22;
            ram[12'h010] <= 8'h99;
            ram[12'h100] <= 8'h40;
            ram[12'h101] <= 8'h41;
            ram[12'h102] <= 8'h42;
            ram[12'h103] <= 8'h43;
            ram[12'hFFF] <= 8'h77;
            mem_rdata    <= 8'h00;
        end else begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            mem_rdata <= ram[mem_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: every ack pops the oldest expectation and checks owner, timing and data
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            sb.delete();
            we_pulses    = 0;
            prev_we      = 1'b0;
            exp_d_rdata  = 8'h00;
            exp_if_rdata = 8'h00;
        end else begin
            if (mem_we) begin
                chk("mem_we_prev_cycle", 32'(prev_we), 32'd0);
                we_pulses++;
            end
            prev_we = mem_we;
            if (d_ack || if_ack) begin
                if (sb.size() == 0) begin
                    chk("spurious_ack", 32'({d_ack, if_ack}), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("ack_owner", 32'({d_ack, if_ack}), e.is_data ? 32'd2 : 32'd1);
                    chk("ack_cycle", 32'(cyc), 32'(e.due));
                    if (e.is_data) begin
                        if (e.is_read) exp_d_rdata = e.data;
                        else chk("store_we_pulses", 32'(we_pulses), 32'd1);
                        we_pulses = 0;
                    end else begin
                        exp_if_rdata = e.data;
                    end
                    chk("d_rdata", 32'(d_rdata), 32'(exp_d_rdata));
                    chk("if_rdata", 32'(if_rdata), 32'(exp_if_rdata));
                end
            end
        end
    end

    task automatic wait_acks();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (d_ack) d_req = 1'b0;
            if (if_ack) if_req = 1'b0;
            if (!d_req && !if_req) break;
        end
        chk("ack_timeout_d", 32'(d_req), 32'd0);
        chk("ack_timeout_if", 32'(if_req), 32'd0);
        d_req  = 1'b0;
        if_req = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        @(negedge clk);
        e.is_data = !v.is_fetch;
        e.is_read = v.is_fetch || !v.we;
        e.data    = v.exp_data;
        e.due     = cyc + v.lat;
        if (v.is_fetch) begin
            if_addr = v.addr;
            if_req  = 1'b1;
        end else begin
            d_we    = v.we;
            d_addr  = v.addr;
            d_wdata = v.wdata;
            d_req   = 1'b1;
        end
        sb.push_back(e);
        wait_acks();
    endtask

    task automatic push_exp(input logic is_data, input logic is_read, input logic [7:0] data, input int due);
        exp_t e;
        e.is_data = is_data;
        e.is_read = is_read;
        e.data    = data;
        e.due     = due;
        sb.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int k;
        int n;
        vecs[0] = '{1'b0, 1'b1, 12'h005, 8'hA5, 8'hA5, 2};
        vecs[1] = '{1'b0, 1'b0, 12'h005, 8'h00, 8'hA5, 3};
        vecs[2] = '{1'b1, 1'b0, 12'h000, 8'h00, 8'hF0, 3};
        vecs[3] = '{1'b1, 1'b0, 12'hFFF, 8'h00, 8'h77, 3};
        vecs[4] = '{1'b0, 1'b1, 12'hFFF, 8'h3C, 8'h3C, 2};
        vecs[5] = '{1'b1, 1'b0, 12'hFFF, 8'h00, 8'h3C, 3};
        vecs[6] = '{1'b0, 1'b0, 12'h000, 8'h00, 8'hF0, 3};
        vecs[7] = '{1'b0, 1'b0, 12'hFFF, 8'h00, 8'h3C, 3};

        reset   = 1'b1;
        preload = 1'b1;
        if_req  = 1'b0;
        if_addr = 12'h000;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = 12'h000;
        d_wdata = 8'h00;
        repeat (3) @(negedge clk);
        preload = 1'b0;
        reset   = 1'b0;
        #1;
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_if_rdata", 32'(if_rdata), 32'd0);
        chk("rst_d_rdata", 32'(d_rdata), 32'd0);
        chk("rst_if_ack", 32'(if_ack), 32'd0);
        chk("rst_d_ack", 32'(d_ack), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Simultaneous fetch and load: data wins, fetch follows four cycles later
        @(negedge clk);
        k = cyc;
        if_addr = 12'h001;
        if_req  = 1'b1;
        d_we    = 1'b0;
        d_addr  = 12'h002;
        d_req   = 1'b1;
        push_exp(1'b1, 1'b1, 8'h22, k + 3);
        push_exp(1'b0, 1'b1, 8'h11, k + 7);
        wait_acks();

        // Back-to-back loads: requester retargets on each ack edge
        @(negedge clk);
        k = cyc;
        n = 0;
        d_we   = 1'b0;
        d_addr = 12'h100;
        d_req  = 1'b1;
        for (int i = 0; i < 4; i++) push_exp(1'b1, 1'b1, 8'(8'h40 + i), k + 3 + 4 * i);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (d_ack) begin
                n++;
                if (n < 4) d_addr = 12'(12'h100 + n);
                else d_req = 1'b0;
            end
            if (!d_req) break;
        end
        chk("b2b_ack_count", 32'(n), 32'd4);
        d_req = 1'b0;

        // Reset during a load's RD_WAIT: aborted, then held request re-arbitrated
        @(negedge clk);
        d_we   = 1'b0;
        d_addr = 12'h002;
        d_req  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("midrun_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("midrun_d_rdata", 32'(d_rdata), 32'd0);
        chk("midrun_if_rdata", 32'(if_rdata), 32'd0);
        chk("midrun_mem_addr", 32'(mem_addr), 32'd0);
        chk("midrun_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("midrun_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("midrun_no_ack", 32'({d_ack, if_ack}), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        k = cyc;
        push_exp(1'b1, 1'b1, 8'h22, k + 3);
        wait_acks();

        // Reset during a store's ISSUE: mem_we drops at once, RAM untouched
        @(negedge clk);
        d_we    = 1'b1;
        d_addr  = 12'h010;
        d_wdata = 8'h55;
        d_req   = 1'b1;
        @(negedge clk);
        chk("store_issue_we", 32'(mem_we), 32'd1);
        reset = 1'b1;
        #1;
        chk("store_abort_we", 32'(mem_we), 32'd0);
        d_req = 1'b0;
        @(negedge clk);
        chk("store_abort_ack", 32'(d_ack), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        chk("ram_010_kept", 32'(ram[12'h010]), 32'h99);
        begin
            vec_t v;
            v = '{1'b0, 1'b0, 12'h010, 8'h00, 8'h99, 3};
            run_vec(v);
        end

        repeat (6) @(negedge clk);
        chk("end_sb_empty", 32'(sb.size()), 32'd0);
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_d_rdata", 32'(d_rdata), 32'h99);
        chk("end_if_rdata", 32'(if_rdata), 32'(exp_if_rdata));
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
